// File: rtl/thermo_pkg.sv
// Shared types and constants for the thermostat control FSM.
// Frost encodings are only reachable when ANTIFREEZE_EN is defined.
package thermo_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_HEAT  = 3'd2,
        ST_COOL  = 3'd3,
        ST_WIN   = 3'd4,
        ST_FROST = 3'd5
    } state_e;

    localparam logic [1:0] LED_OFF  = 2'b00;
    localparam logic [1:0] LED_HEAT = 2'b01;
    localparam logic [1:0] LED_COOL = 2'b10;
    localparam logic [1:0] LED_STBY = 2'b11;

    localparam logic [1:0] WC_NONE  = 2'b00;
    localparam logic [1:0] WC_HEAT  = 2'b01;
    localparam logic [1:0] WC_COOL  = 2'b10;
    localparam logic [1:0] WC_FROST = 2'b11;

    localparam logic signed [3:0] COMFORT_TH     = 4'sd1;
    localparam logic signed [3:0] FROST_ENTER_TH = 4'sd3;
    localparam logic signed [3:0] FROST_EXIT_TH  = 4'sd1;

    // Widen the 3-bit two's complement error so thresholds up to 7 compare cleanly.
    function automatic logic signed [3:0] sext_delta(input logic [2:0] d);
        return $signed({d[2], d});
    endfunction

endpackage

// File: rtl/thermo_hold_timer.sv
// Minimum-on-time counter: clear on entry, count while running, saturate,
// and flag once the count has reached MIN_ON_CYC.
module thermo_hold_timer #(
    parameter int MIN_ON_CYC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CW = $clog2(MIN_ON_CYC + 1);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MIN_ON_CYC);

    logic [CW-1:0] hold_q;
    logic [CW-1:0] hold_d;

    // Next count: clear wins over increment, increment stops at the limit.
    always_comb begin
        hold_d = hold_q;
        if (clr_i) begin
            hold_d = '0;
        end else if (en_i && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + CW'(1);
        end else begin
            hold_d = hold_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign done_o = (hold_q >= HOLD_MAX);

endmodule

// File: rtl/thermostat_ctrl_fsm.sv
// Thermostat control FSM: heat/cool/idle decision, window and run overrides.
// Optional ANTIFREEZE_EN adds a FROST sub-state of WIN driving the antifreeze circuit.
module thermostat_ctrl_fsm
    import thermo_pkg::*;
#(
    parameter int MIN_ON_CYC = 2,
    parameter int ECO_TH     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active,
    input  logic       RUN,
    input  logic       WS,
    input  logic [2:0] DELTA,
    output logic [1:0] LED,
    output logic [1:0] ID_WC,
    output logic       T_WC,
    output logic       CLR_WC
);

    state_e state_q;
    state_e state_d;
    logic   clr_wc_q;
    logic   clr_wc_d;

    logic signed [3:0] delta_s;
    logic signed [3:0] ts_s;
    logic              hold_done_s;
    logic              enter_run_s;
    logic              in_run_s;

    assign delta_s  = sext_delta(DELTA);
    assign ts_s     = active ? COMFORT_TH : $signed(4'(ECO_TH));
    assign in_run_s = (state_q == ST_HEAT) || (state_q == ST_COOL);

    thermo_hold_timer #(
        .MIN_ON_CYC (MIN_ON_CYC)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (enter_run_s),
        .en_i   (in_run_s),
        .done_o (hold_done_s)
    );

    // Next state: RUN off beats window open, which beats the thermal rules.
    always_comb begin
        state_d = state_q;
        if (!RUN) begin
            state_d = ST_OFF;
        end else if (!WS) begin
`ifdef ANTIFREEZE_EN
            case (state_q)
                ST_WIN:   state_d = (delta_s >= FROST_ENTER_TH) ? ST_FROST : ST_WIN;
                ST_FROST: state_d = (delta_s <= FROST_EXIT_TH) ? ST_WIN : ST_FROST;
                default:  state_d = ST_WIN;
            endcase
`else
            state_d = ST_WIN;
`endif
        end else begin
            case (state_q)
                ST_OFF, ST_WIN, ST_FROST: state_d = ST_IDLE;
                ST_IDLE: begin
                    if (delta_s >= ts_s) begin
                        state_d = ST_HEAT;
                    end else if (delta_s <= -ts_s) begin
                        state_d = ST_COOL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HEAT: state_d = ((delta_s <= 4'sd0) && hold_done_s) ? ST_IDLE : ST_HEAT;
                ST_COOL: state_d = ((delta_s >= 4'sd0) && hold_done_s) ? ST_IDLE : ST_COOL;
                default: state_d = ST_OFF;
            endcase
        end
    end

    assign enter_run_s = ((state_d == ST_HEAT) || (state_d == ST_COOL)) && (state_d != state_q);
    assign clr_wc_d    = enter_run_s;

    // State and clear-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_OFF;
            clr_wc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            clr_wc_q <= clr_wc_d;
        end
    end

    // Moore decode of the state register onto LEDs and the water circuit.
    always_comb begin
        LED   = LED_OFF;
        ID_WC = WC_NONE;
        T_WC  = 1'b0;
        case (state_q)
            ST_OFF: begin
                LED = LED_OFF;  ID_WC = WC_NONE; T_WC = 1'b0;
            end
            ST_IDLE, ST_WIN: begin
                LED = LED_STBY; ID_WC = WC_NONE; T_WC = 1'b0;
            end
            ST_HEAT: begin
                LED = LED_HEAT; ID_WC = WC_HEAT; T_WC = 1'b1;
            end
            ST_COOL: begin
                LED = LED_COOL; ID_WC = WC_COOL; T_WC = 1'b1;
            end
            ST_FROST: begin
`ifdef ANTIFREEZE_EN
                LED = LED_STBY; ID_WC = WC_FROST; T_WC = 1'b1;
`else
                LED = LED_STBY; ID_WC = WC_NONE; T_WC = 1'b0;
`endif
            end
            default: begin
                LED = LED_OFF;  ID_WC = WC_NONE; T_WC = 1'b0;
            end
        endcase
    end

    assign CLR_WC = clr_wc_q;

endmodule

// File: tb/tb_thermostat_ctrl_fsm.sv
// Scoreboard bench: stimulus side runs a behavioural model and queues the
// expected outputs; an independent monitor pops and compares every cycle.
module tb_thermostat_ctrl_fsm;

    localparam int MIN_ON = 2;
    localparam int ECO    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       active;
    logic       RUN;
    logic       WS;
    logic [2:0] DELTA;
    logic [1:0] LED;
    logic [1:0] ID_WC;
    logic       T_WC;
    logic       CLR_WC;

    thermostat_ctrl_fsm #(.MIN_ON_CYC(MIN_ON), .ECO_TH(ECO)) dut (
        .clk    (clk),
        .rst    (rst),
        .active (active),
        .RUN    (RUN),
        .WS     (WS),
        .DELTA  (DELTA),
        .LED    (LED),
        .ID_WC  (ID_WC),
        .T_WC   (T_WC),
        .CLR_WC (CLR_WC)
    );

    always #5 clk = ~clk;

    // Model modes: 0 off, 1 idle, 2 heat, 3 cool, 4 window, 5 frost
    int m_mode = 0;
    int m_hold = 0;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [5:0] exp_q[$];

    // LED, circuit id, pump per mode
    int led_tab [6] = '{0, 3, 1, 2, 3, 3};
    int id_tab  [6] = '{0, 0, 1, 2, 0, 3};
    int pump_tab[6] = '{0, 0, 1, 1, 0, 1};

    task automatic step(input logic r, input logic run_v, input logic ws_v,
                        input logic act_v, input logic [2:0] d3);
        int d;
        int ts;
        int nm;
        int clr;
        @(negedge clk);
        rst = r; RUN = run_v; WS = ws_v; active = act_v; DELTA = d3;
        d  = $signed(d3);
        ts = act_v ? 1 : ECO;
        if (r) nm = 0;
        else if (!run_v) nm = 0;
        else if (!ws_v) begin
`ifdef ANTIFREEZE_EN
            if (m_mode == 4) nm = (d >= 3) ? 5 : 4;
            else if (m_mode == 5) nm = (d <= 1) ? 4 : 5;
            else nm = 4;
`else
            nm = 4;
`endif
        end else if (m_mode == 1) begin
            if (d >= ts) nm = 2;
            else if (d <= -ts) nm = 3;
            else nm = 1;
        end else if (m_mode == 2) nm = (d <= 0 && m_hold >= MIN_ON) ? 1 : 2;
        else if (m_mode == 3) nm = (d >= 0 && m_hold >= MIN_ON) ? 1 : 3;
        else nm = 1;
        clr = ((nm == 2 || nm == 3) && nm != m_mode) ? 1 : 0;
        if (clr == 1) m_hold = 0;
        else if (nm == m_mode && (nm == 2 || nm == 3)) m_hold = (m_hold + 1 > MIN_ON) ? MIN_ON : m_hold + 1;
        if (r) m_hold = 0;
        m_mode = nm;
        exp_q.push_back({2'(led_tab[nm]), 2'(id_tab[nm]), 1'(pump_tab[nm]), 1'(clr)});
    endtask

    // Monitor: one expected record per edge, compared just after the edge.
    initial begin
        logic [5:0] e;
        logic [5:0] got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {LED, ID_WC, T_WC, CLR_WC};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d got LED/ID/T/CLR=%b required=%b", cyc, got, e);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; RUN = 1'b0; WS = 1'b1; active = 1'b0; DELTA = 3'b000;
        // reset, then off, then idle in eco mode
        step(1, 0, 1, 0, 3'b000);
        step(1, 0, 1, 0, 3'b000);
        step(0, 0, 1, 0, 3'b000);
        step(0, 1, 1, 0, 3'b000);
        step(0, 1, 1, 0, 3'b001);
        step(0, 1, 1, 0, 3'b011);
        step(0, 1, 1, 0, 3'b011);
        // heat held by min-on, then idle, then cool
        repeat (5) step(0, 1, 1, 0, 3'b110);
        // comfort mode thresholds
        step(0, 1, 1, 1, 3'b000);
        repeat (4) step(0, 1, 1, 1, 3'b000);
        step(0, 1, 1, 1, 3'b001);
        repeat (3) step(0, 1, 1, 1, 3'b000);
        step(0, 1, 1, 1, 3'b111);
        repeat (3) step(0, 1, 1, 1, 3'b100);
        // window open from heat, then close and re-heat
        step(0, 1, 1, 1, 3'b000);
        step(0, 1, 1, 1, 3'b010);
        step(0, 1, 0, 1, 3'b010);
        step(0, 1, 0, 1, 3'b011);
        step(0, 1, 0, 1, 3'b011);
        step(0, 1, 0, 1, 3'b001);
        step(0, 1, 1, 1, 3'b010);
        step(0, 1, 1, 1, 3'b010);
        // cool then run off immediately
        step(0, 1, 1, 1, 3'b000);
        step(0, 1, 1, 1, 3'b000);
        step(0, 1, 1, 1, 3'b000);
        step(0, 1, 1, 1, 3'b100);
        step(0, 0, 1, 1, 3'b100);
        // mid-operation reset
        step(0, 1, 1, 1, 3'b011);
        step(0, 1, 1, 1, 3'b011);
        step(1, 1, 1, 1, 3'b011);
        // randomized traffic, biased toward run enabled and window closed
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)));
        end
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
